// File: rtl/ram_port_requester_if.sv
// Request/response handshake bundle for ram_port_requester.
// master = initiator driving requests; slave = the requester block.
interface ram_port_requester_if #(
  parameter int DATA_WIDTH = 4,
  parameter int ADDR_WIDTH = 5
);
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_data;
  logic                  req_we;
  logic                  req_valid;
  logic                  req_ready;
  logic [DATA_WIDTH-1:0] resp_data;
  logic                  resp_is_wr;
  logic                  resp_valid;
  logic                  resp_ready;

  modport master (
    output req_addr, req_data, req_we, req_valid, resp_ready,
    input  req_ready, resp_data, resp_is_wr, resp_valid
  );

  modport slave (
    input  req_addr, req_data, req_we, req_valid, resp_ready,
    output req_ready, resp_data, resp_is_wr, resp_valid
  );
endinterface

// File: rtl/ram_port_requester.sv
// Drives one RAM port from a valid/ready request channel and returns in-order responses through a credit-checked FIFO.
// Latency 2 cycles accept->resp_valid; req_ready drops once FIFO + in-flight reaches RESP_DEPTH. Option: RAM_PORT_REQUESTER_WR_RESP_EN.
module ram_port_requester #(
  parameter int DATA_WIDTH = 4,
  parameter int SIZE       = 32,
  parameter int ADDR_WIDTH = $clog2(SIZE),
  parameter int RESP_DEPTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  ram_port_requester_if.slave   req_if,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  output logic                  ram_wr_en_o,
  output logic                  ram_rd_en_o,
  input  logic [DATA_WIDTH-1:0] ram_rd_data_i
);

  localparam int CW = $clog2(RESP_DEPTH + 1);
  localparam int PW = $clog2(RESP_DEPTH);

  if (RESP_DEPTH < 2 || SIZE > (1 << ADDR_WIDTH)) begin : g_cfg_err
    $error("ram_port_requester: RESP_DEPTH must be >= 2 and SIZE must fit ADDR_WIDTH");
  end

  logic          accept;
  logic          pop;
  logic          push;
  logic          resp_due;
  logic [CW:0]   occ_after;
  logic [DATA_WIDTH-1:0] push_data;

  logic          pend_q,   pend_d;
  logic [CW-1:0] count_q,  count_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] data_q [RESP_DEPTH];

  // Credits count both queued entries and the one response still coming back from the RAM.
  assign occ_after      = {1'b0, count_q} + (CW+1)'(pend_q) - (CW+1)'(pop);
  assign req_if.req_ready = ~rst & (occ_after < (CW+1)'(RESP_DEPTH));
  assign accept         = req_if.req_valid & req_if.req_ready;

  assign req_if.resp_valid = ~rst & (count_q != '0);
  assign pop               = req_if.resp_valid & req_if.resp_ready;
  assign push              = pend_q;

  assign ram_addr_o  = req_if.req_addr;
  assign ram_data_o  = req_if.req_data;
  assign ram_rd_en_o = accept & ~req_if.req_we;
  assign ram_wr_en_o = accept &  req_if.req_we;

  assign req_if.resp_data = req_if.resp_valid ? data_q[rd_ptr_q] : '0;

`ifdef RAM_PORT_REQUESTER_WR_RESP_EN
  logic pend_wr_q, pend_wr_d;
  logic iswr_q [RESP_DEPTH];

  assign resp_due  = accept;
  assign pend_wr_d = accept & req_if.req_we;
  assign push_data = pend_wr_q ? '0 : ram_rd_data_i;
  assign req_if.resp_is_wr = req_if.resp_valid & iswr_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_wr_q <= 1'b0;
    end else begin
      pend_wr_q <= pend_wr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      iswr_q[wr_ptr_q] <= pend_wr_q;
    end
  end
`else
  assign resp_due  = accept & ~req_if.req_we;
  assign push_data = ram_rd_data_i;
  assign req_if.resp_is_wr = 1'b0;
`endif

  always_comb begin
    pend_d   = resp_due;
    count_d  = count_q + CW'(push) - CW'(pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == PW'(RESP_DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PW'(RESP_DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q   <= 1'b0;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      pend_q   <= pend_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      data_q[wr_ptr_q] <= push_data;
    end
  end

endmodule

// File: tb/tb_ram_port_requester.sv
// Directed bench for ram_port_requester with a one-cycle-latency RAM model attached to the port.
module tb_ram_port_requester;
  logic clk = 1'b0;
  logic rst;
  logic [4:0] ram_addr;
  logic [3:0] ram_data;
  logic       ram_wr_en;
  logic       ram_rd_en;
  logic [3:0] ram_rd_data;

  logic       pl_en;
  logic [4:0] pl_addr;
  logic [3:0] pl_dat;
  logic [3:0] mem [32];

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ram_port_requester_if #(.DATA_WIDTH(4), .ADDR_WIDTH(5)) bus ();

  ram_port_requester #(
    .DATA_WIDTH(4), .SIZE(32), .ADDR_WIDTH(5), .RESP_DEPTH(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .req_if        (bus),
    .ram_addr_o    (ram_addr),
    .ram_data_o    (ram_data),
    .ram_wr_en_o   (ram_wr_en),
    .ram_rd_en_o   (ram_rd_en),
    .ram_rd_data_i (ram_rd_data)
  );

  always @(posedge clk) begin
    if (pl_en) mem[pl_addr] <= pl_dat;
    else if (ram_wr_en) mem[ram_addr] <= ram_data;
    if (ram_rd_en) ram_rd_data <= mem[ram_addr];
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [4:0] a, input logic [3:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_addr = a; pl_dat = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  task automatic drive(input logic vld, input logic we, input logic [4:0] a,
                       input logic [3:0] d, input logic rr);
    @(negedge clk);
    bus.req_valid = vld; bus.req_we = we; bus.req_addr = a;
    bus.req_data = d; bus.resp_ready = rr;
    #1;
  endtask

  initial begin
    rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_dat = '0;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0;
    bus.req_data = '0; bus.resp_ready = 1'b0;

    // reset state, with a request offered
    drive(1'b1, 1'b0, 5'd3, 4'h0, 1'b1);
    drive(1'b1, 1'b0, 5'd3, 4'h0, 1'b1);
    check_val("rst_req_ready", 32'(bus.req_ready), 32'd0);
    check_val("rst_rd_en", 32'(ram_rd_en), 32'd0);
    check_val("rst_wr_en", 32'(ram_wr_en), 32'd0);
    check_val("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    check_val("rst_resp_data", 32'(bus.resp_data), 32'd0);
    check_val("rst_resp_is_wr", 32'(bus.resp_is_wr), 32'd0);
    @(negedge clk);
    rst = 1'b0; bus.req_valid = 1'b0;

    // single read
    preload(5'd5, 4'hA);
    drive(1'b1, 1'b0, 5'd5, 4'h0, 1'b1);
    check_val("single_ready", 32'(bus.req_ready), 32'd1);
    check_val("single_rd_en_n", 32'(ram_rd_en), 32'd1);
    drive(1'b0, 1'b0, 5'd0, 4'h0, 1'b1);
    check_val("single_rd_en_n1", 32'(ram_rd_en), 32'd0);
    check_val("single_vld_n1", 32'(bus.resp_valid), 32'd0);
    drive(1'b0, 1'b0, 5'd0, 4'h0, 1'b1);
    check_val("single_vld_n2", 32'(bus.resp_valid), 32'd1);
    check_val("single_data", 32'(bus.resp_data), 32'hA);
    check_val("single_is_wr", 32'(bus.resp_is_wr), 32'd0);
    drive(1'b0, 1'b0, 5'd0, 4'h0, 1'b1);
    check_val("single_vld_n3", 32'(bus.resp_valid), 32'd0);

    // streaming
    for (int i = 0; i < 8; i++) preload(5'(i), 4'(i));
    for (int c = 0; c < 10; c++) begin
      drive(c < 8, 1'b0, 5'(c), 4'h0, 1'b1);
      if (c < 8) check_val("stream_ready", 32'(bus.req_ready), 32'd1);
      if (c < 2) begin
        check_val("stream_early_vld", 32'(bus.resp_valid), 32'd0);
      end else begin
        check_val("stream_vld", 32'(bus.resp_valid), 32'd1);
        check_val("stream_data", 32'(bus.resp_data), 32'(c - 2));
      end
    end
    drive(1'b0, 1'b0, 5'd0, 4'h0, 1'b1);
    check_val("stream_drained", 32'(bus.resp_valid), 32'd0);

    // backpressure
    drive(1'b1, 1'b0, 5'd1, 4'h0, 1'b0);
    check_val("bp_ready0", 32'(bus.req_ready), 32'd1);
    drive(1'b1, 1'b0, 5'd2, 4'h0, 1'b0);
    check_val("bp_ready1", 32'(bus.req_ready), 32'd1);
    drive(1'b1, 1'b0, 5'd3, 4'h0, 1'b0);
    check_val("bp_ready2", 32'(bus.req_ready), 32'd0);
    check_val("bp_rd_en2", 32'(ram_rd_en), 32'd0);
    drive(1'b1, 1'b0, 5'd3, 4'h0, 1'b0);
    check_val("bp_ready3", 32'(bus.req_ready), 32'd0);
    check_val("bp_vld3", 32'(bus.resp_valid), 32'd1);
    drive(1'b1, 1'b0, 5'd3, 4'h0, 1'b1);
    check_val("bp_pop_ready", 32'(bus.req_ready), 32'd1);
    check_val("bp_pop_data", 32'(bus.resp_data), 32'd1);
    drive(1'b0, 1'b0, 5'd0, 4'h0, 1'b0);
    check_val("bp_ready5", 32'(bus.req_ready), 32'd0);
    check_val("bp_data5", 32'(bus.resp_data), 32'd2);
    drive(1'b0, 1'b0, 5'd0, 4'h0, 1'b1);
    check_val("bp_data6", 32'(bus.resp_data), 32'd2);
    drive(1'b0, 1'b0, 5'd0, 4'h0, 1'b1);
    check_val("bp_data7", 32'(bus.resp_data), 32'd3);
    check_val("bp_vld7", 32'(bus.resp_valid), 32'd1);
    drive(1'b0, 1'b0, 5'd0, 4'h0, 1'b1);
    check_val("bp_vld8", 32'(bus.resp_valid), 32'd0);

    // write then read same address
    drive(1'b1, 1'b1, 5'd9, 4'h3, 1'b1);
    check_val("wr_wr_en", 32'(ram_wr_en), 32'd1);
    check_val("wr_ready", 32'(bus.req_ready), 32'd1);
    drive(1'b1, 1'b0, 5'd9, 4'h0, 1'b1);
    check_val("raw_rd_en", 32'(ram_rd_en), 32'd1);
    drive(1'b0, 1'b0, 5'd0, 4'h0, 1'b1);
`ifdef RAM_PORT_REQUESTER_WR_RESP_EN
    check_val("raw_wr_vld", 32'(bus.resp_valid), 32'd1);
    check_val("raw_wr_is_wr", 32'(bus.resp_is_wr), 32'd1);
    check_val("raw_wr_data", 32'(bus.resp_data), 32'd0);
`else
    check_val("raw_no_wr_resp", 32'(bus.resp_valid), 32'd0);
`endif
    drive(1'b0, 1'b0, 5'd0, 4'h0, 1'b1);
    check_val("raw_rd_vld", 32'(bus.resp_valid), 32'd1);
    check_val("raw_rd_data", 32'(bus.resp_data), 32'd3);
    check_val("raw_rd_is_wr", 32'(bus.resp_is_wr), 32'd0);
    drive(1'b0, 1'b0, 5'd0, 4'h0, 1'b1);
    check_val("raw_done", 32'(bus.resp_valid), 32'd0);

    // reset mid-stream: one response queued, one read in flight
    drive(1'b1, 1'b0, 5'd1, 4'h0, 1'b0);
    drive(1'b1, 1'b0, 5'd2, 4'h0, 1'b0);
    @(negedge clk);
    rst = 1'b1; bus.req_valid = 1'b1; bus.req_addr = 5'd3;
    #1;
    check_val("mrst_vld", 32'(bus.resp_valid), 32'd0);
    check_val("mrst_ready", 32'(bus.req_ready), 32'd0);
    check_val("mrst_rd_en", 32'(ram_rd_en), 32'd0);
    check_val("mrst_data", 32'(bus.resp_data), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 1'b0; bus.resp_ready = 1'b1;
    #1;
    check_val("post_rst_vld0", 32'(bus.resp_valid), 32'd0);
    drive(1'b0, 1'b0, 5'd0, 4'h0, 1'b1);
    check_val("post_rst_vld1", 32'(bus.resp_valid), 32'd0);
    drive(1'b1, 1'b0, 5'd6, 4'h0, 1'b1);
    check_val("post_rst_ready", 32'(bus.req_ready), 32'd1);
    check_val("post_rst_vld2", 32'(bus.resp_valid), 32'd0);
    drive(1'b0, 1'b0, 5'd0, 4'h0, 1'b1);
    check_val("post_rst_vld3", 32'(bus.resp_valid), 32'd0);
    drive(1'b0, 1'b0, 5'd0, 4'h0, 1'b1);
    check_val("post_rst_vld4", 32'(bus.resp_valid), 32'd1);
    check_val("post_rst_data", 32'(bus.resp_data), 32'd6);
    drive(1'b0, 1'b0, 5'd0, 4'h0, 1'b1);
    check_val("post_rst_empty", 32'(bus.resp_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
